// File: rtl/vga_digit_display.sv
// Draws an unsigned binary value as N_DIGITS seven-segment decimal glyphs on the VGA raster.
// The value is captured once per frame and converted to BCD by a sequential double-dabble engine.
module vga_digit_display #(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned VAL_W      = 14,
  parameter int unsigned START_X    = 85,
  parameter int unsigned START_Y    = 150,
  parameter int unsigned SEG_W      = 20,
  parameter int unsigned SEG_H      = 40,
  parameter int unsigned PITCH      = 30,
  parameter int unsigned BLANK_LEAD = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [11:0]      VGA_horzCoord,
  input  logic [11:0]      VGA_vertCoord,
  input  logic             frame_start,
  input  logic [VAL_W-1:0] value,
  output logic             busy,
  output logic             OUTPUT
);

  localparam int unsigned BcdW = 4 * N_DIGITS;
  localparam int unsigned CntW = (VAL_W > 1) ? $clog2(VAL_W) : 1;

  function automatic int unsigned pow10_max(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned k = 0; k < n; k++) p = p * 10;
    return p - 1;
  endfunction

  localparam int unsigned      MaxVal  = pow10_max(N_DIGITS);
  localparam logic [CntW-1:0] LastCnt = CntW'(VAL_W - 1);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  typedef enum logic [0:0] {StIdle, StConv} state_t;

  state_t          r_state;
  logic [VAL_W-1:0] r_bin;
  logic [BcdW-1:0] r_bcd;
  logic [BcdW-1:0] r_disp;
  logic [CntW-1:0] r_cnt;
  logic            r_sat;
  logic            r_busy;
  logic            r_out;

  logic [BcdW-1:0] w_bcd_adj;
  logic [BcdW-1:0] w_bcd_shift;
  logic [BcdW-1:0] w_nines;
  logic            w_over;

  assign w_nines = {N_DIGITS{4'd9}};
  assign w_over  = 64'(value) > 64'(MaxVal);

  // Double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  assign w_bcd_shift = {w_bcd_adj[BcdW-2:0], r_bin[VAL_W-1]};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= StIdle;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_busy  <= 1'b0;
      r_disp  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (frame_start) begin
            r_bin   <= value;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_sat   <= w_over;
            r_busy  <= 1'b1;
            r_state <= StConv;
          end
        end
        StConv: begin
          r_bin <= r_bin << 1;
          r_bcd <= w_bcd_shift;
          r_cnt <= r_cnt + 1'b1;
          // Display register only ever takes the complete result.
          if (r_cnt == LastCnt) begin
            r_disp  <= r_sat ? w_nines : w_bcd_shift;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  logic [12:0]         w_x;
  logic [12:0]         w_y;
  logic [N_DIGITS-1:0] w_nz;
  logic [N_DIGITS-1:0] w_lit;

  assign w_x = {1'b0, VGA_horzCoord};
  assign w_y = {1'b0, VGA_vertCoord};

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    localparam logic [12:0] X0   = 13'(START_X + gi * PITCH);
    localparam logic [12:0] X1   = 13'(START_X + gi * PITCH + SEG_W);
    localparam logic [12:0] Y0   = 13'(START_Y);
    localparam logic [12:0] YM   = 13'(START_Y + SEG_H / 2);
    localparam logic [12:0] Y1   = 13'(START_Y + SEG_H);
    localparam bit          IsLs = (gi == N_DIGITS - 1);

    logic [3:0] w_nib;
    logic [6:0] w_hit;
    logic       w_hin;
    logic       w_up;
    logic       w_lo;
    logic       w_blank;

    assign w_nib    = r_disp[4*(N_DIGITS-1-gi) +: 4];
    assign w_nz[gi] = |w_nib;
    assign w_hin    = (w_x > X0) && (w_x < X1);
    assign w_up     = (w_y > Y0) && (w_y <= YM);
    assign w_lo     = (w_y > YM) && (w_y < Y1);

    // Bit order matches seg7: {a,b,c,d,e,f,g}.
    assign w_hit = {(w_y == Y0) && w_hin, (w_x == X1) && w_up, (w_x == X1) && w_lo,
                    (w_y == Y1) && w_hin, (w_x == X0) && w_lo, (w_x == X0) && w_up,
                    (w_y == YM) && w_hin};

    assign w_blank   = (BLANK_LEAD != 0) && !IsLs && !(|w_nz[gi:0]);
    assign w_lit[gi] = !w_blank && |(seg7(w_nib) & w_hit);
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_out <= 1'b0;
    else       r_out <= |w_lit;
  end

  assign busy   = r_busy;
  assign OUTPUT = r_out;

endmodule
